// File: rtl/npu_pkg.sv
// Shared definitions for the operand loader: FSM encoding and frame layout.
package npu_pkg;

    // Loader states: collecting words, one-cycle start pulse, waiting on the controller.
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Frame layout: 3 x words, then 9 row-major weights, then 3 biases.
    localparam int FRAME_WORDS = 15;
    localparam int X_BASE      = 0;
    localparam int W_BASE      = 3;
    localparam int B_BASE      = 12;

    localparam int N_X   = W_BASE - X_BASE;
    localparam int N_W   = B_BASE - W_BASE;
    localparam int N_B   = FRAME_WORDS - B_BASE;
    localparam int IDX_W = 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

    // True when the running word index addresses the given frame slot.
    function automatic logic idx_hit(input logic [IDX_W-1:0] idx, input int slot);
        return idx == IDX_W'(slot);
    endfunction

endpackage

// File: rtl/operand_loader_if.sv
// Bundle between the operand loader, its word stream and the dense-layer controller.
interface operand_loader_if #(
    parameter int DW = 16
);
    // Operand stream
    logic                   in_valid;
    logic                   in_ready;
    logic [2*DW-1:0]        in_data;
    logic                   in_last;

    // Registered operands presented to the controller
    logic signed [DW-1:0]   x0, x1, x2;
    logic signed [DW-1:0]   w00, w01, w02;
    logic signed [DW-1:0]   w10, w11, w12;
    logic signed [DW-1:0]   w20, w21, w22;
    logic signed [2*DW-1:0] b0, b1, b2;

    // Control and status
    logic                   start;
    logic                   done;
    logic                   busy;
    logic                   err_frame;

    // Loader side
    modport slave (
        input  in_valid, in_data, in_last, done,
        output in_ready,
        output x0, x1, x2,
        output w00, w01, w02, w10, w11, w12, w20, w21, w22,
        output b0, b1, b2,
        output start, busy, err_frame
    );

    // Producer / controller side
    modport master (
        output in_valid, in_data, in_last, done,
        input  in_ready,
        input  x0, x1, x2,
        input  w00, w01, w02, w10, w11, w12, w20, w21, w22,
        input  b0, b1, b2,
        input  start, busy, err_frame
    );

endinterface

// File: rtl/operand_loader.sv
// Assembles a 15-word operand stream into x/W/b registers, fires a one-cycle
// start once a correctly framed set is complete, then blocks the stream until
// the controller reports done.
module operand_loader
    import npu_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst,
    operand_loader_if.slave bus
);

    // Control state
    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic              r_start;
    logic              r_busy;
    logic              r_ready;
    logic              r_err;

    // Operand storage
    logic signed [DW-1:0]   r_x [N_X];
    logic signed [DW-1:0]   r_w [N_W];
    logic signed [2*DW-1:0] r_b [N_B];

    // Handshake and frame decode
    logic              w_in_ready;
    logic              w_accept;
    logic              w_at_last;
    logic              w_commit;
    logic              w_early_last;
    logic              w_missing_last;
    logic [N_X-1:0]    w_x_we;
    logic [N_W-1:0]    w_w_we;
    logic [N_B-1:0]    w_b_we;

    // Ready is qualified by reset so it drops the instant reset is asserted.
    assign w_in_ready     = rst & r_ready;
    assign w_accept       = bus.in_valid & w_in_ready;
    assign w_at_last      = (r_idx == LAST_IDX);
    assign w_commit       = w_accept &  bus.in_last &  w_at_last;
    assign w_early_last   = w_accept &  bus.in_last & ~w_at_last;
    assign w_missing_last = w_accept & ~bus.in_last &  w_at_last;

    // Write-enable decode: one enable per destination register, from the word index.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_x_we = '0;
        w_w_we = '0;
        w_b_we = '0;
        for (int i = 0; i < N_X; i++) w_x_we[i] = w_accept & idx_hit(r_idx, X_BASE + i);
        for (int i = 0; i < N_W; i++) w_w_we[i] = w_accept & idx_hit(r_idx, W_BASE + i);
        for (int i = 0; i < N_B; i++) w_b_we[i] = w_accept & idx_hit(r_idx, B_BASE + i);
    end

    // Frame FSM: tracks the word index, checks framing and drives start/busy/ready/err.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= LOAD;
            r_idx   <= '0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                LOAD: begin
                    if (w_commit) begin
                        r_state <= FIRE;
                        r_idx   <= '0;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                    end else if (w_early_last || w_missing_last) begin
                        // Bad framing: restart collection, keep whatever was already written.
                        r_idx <= '0;
                        r_err <= 1'b1;
                    end else if (w_accept) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                FIRE: begin
                    r_state <= WAIT;
                    r_start <= 1'b0;
                end
                WAIT: begin
                    if (bus.done) begin
                        r_state <= LOAD;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= LOAD;
                    r_idx   <= '0;
                    r_start <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Operand registers: each accepted word lands in the slot its index selects.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: operand storage is reset because it drives outputs that must read zero during reset.
            for (int i = 0; i < N_X; i++) r_x[i] <= '0;
            for (int i = 0; i < N_W; i++) r_w[i] <= '0;
            for (int i = 0; i < N_B; i++) r_b[i] <= '0;
        end else begin
            // x and W keep only the low half of the word; biases take the full word.
            for (int i = 0; i < N_X; i++) if (w_x_we[i]) r_x[i] <= bus.in_data[DW-1:0];
            for (int i = 0; i < N_W; i++) if (w_w_we[i]) r_w[i] <= bus.in_data[DW-1:0];
            for (int i = 0; i < N_B; i++) if (w_b_we[i]) r_b[i] <= bus.in_data;
        end
    end

    // Output mapping
    assign bus.in_ready  = w_in_ready;
    assign bus.start     = r_start;
    assign bus.busy      = r_busy;
    assign bus.err_frame = r_err;

    assign bus.x0  = r_x[0];
    assign bus.x1  = r_x[1];
    assign bus.x2  = r_x[2];
    assign bus.w00 = r_w[0];
    assign bus.w01 = r_w[1];
    assign bus.w02 = r_w[2];
    assign bus.w10 = r_w[3];
    assign bus.w11 = r_w[4];
    assign bus.w12 = r_w[5];
    assign bus.w20 = r_w[6];
    assign bus.w21 = r_w[7];
    assign bus.w22 = r_w[8];
    assign bus.b0  = r_b[0];
    assign bus.b1  = r_b[1];
    assign bus.b2  = r_b[2];

endmodule
